dffram_arbiter: RTL and testbench
=================================

Name: dffram_arbiter

Overview:
Two-requester arbiter that shares one single-port, byte-maskable DFFRAM macro (CLK/EN0/WE0/A0/Di0/Do0 interface, 128x32 by default) between two independent masters. Each master uses a valid/ready request channel and an unstalled read-response channel. The block sits directly in front of the RAM macro and owns all of its control pins. It grants round-robin or fixed-priority, and tracks in-flight reads so each read response returns to the requester that issued it.

Parameters:
WORDS, 128, RAM depth in 32-bit words; AW = $clog2(WORDS) (7 at default)
WSIZE, 4, bytes per word; data width DW = 8*WSIZE; write-mask width = WSIZE
RAM_LAT, 1, cycles from the RAM sampling EN0/A0 at a CLK edge to valid Do0; legal values 1..3
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, M0 wins

Ports:
CLK  in  1  single clock; the RAM macro shares this clock
RST_N  in  1  reset, asynchronous, active-low
m0_req_valid  in  1  M0 request present
m0_req_ready  out  1  M0 request accepted this cycle
m0_req_we  in  WSIZE  byte write mask; 0 = read
m0_req_addr  in  AW  word address
m0_req_wdata  in  DW  write data
m0_rsp_valid  out  1  M0 read data valid, one-cycle pulse
m0_rsp_rdata  out  DW  M0 read data
m1_*  same set for M1
EN0  out  1  RAM enable
WE0  out  WSIZE  RAM byte write enables
A0  out  AW  RAM address
Di0  out  DW  RAM write data
Do0  in  DW  RAM read data

Behaviour:
- Reset (RST_N low, asynchronous):
  - rsp_valid both 0; in-flight pipeline cleared; RR pointer set so M0 wins the first tie.
  - Requests arriving during reset are not accepted.
- Arbitration is combinational each cycle:
  - grant goes to a valid requester; mX_req_ready = grant to X; at most one ready high.
  - A request is accepted when valid && ready.
  - Requesters must hold addr/we/wdata stable until accepted.
- Tie-breaking:
  - RR mode: on a tie, grant the requester not granted most recently; the pointer updates only on acceptance.
  - Fixed mode: M0 always wins a tie; M1 can be starved, and this is accepted behaviour.
- RAM pins are combinational from the granted request:
  - EN0 = 1; WE0 = mask; A0 = addr; Di0 = wdata.
  - With no grant: EN0 = 0, WE0 = 0, A0 = 0, Di0 = 0.
- Throughput: one access per cycle sustained, with no bubble when switching requesters.
- Read (mask == 0):
  - Requester id plus a valid bit enter a RAM_LAT-deep shift pipeline.
  - Exactly RAM_LAT cycles after the accepting edge, the owner's rsp_valid = 1 and rsp_rdata = Do0.
  - The other requester's rsp_rdata holds its last value.
- Write (mask != 0): no response; only masked bytes change.
- Partial mask reads nothing back.
- Responses cannot stall: the requester must accept rsp_valid pulses.
- Back-to-back reads from alternating requesters return in issue order, one per cycle.
- Read-after-write, same address: a read accepted the cycle after the write returns the new data.
- Out-of-range address (WORDS not a power of two): passed through unchanged; the result is RAM-defined.
- Reset mid-operation: pending responses are dropped; no rsp_valid after reset deasserts until new reads are accepted.
- Valid dropped without acceptance: legal; no state changes.

Decomposition:
- Package dffram_arb_pkg holds:
  - default WORDS/WSIZE/RAM_LAT constants
  - requester-id typedef (1 bit)
  - ARB_MODE encodings (ARB_RR = 0, ARB_FIXED = 1)
- Sub-module arb2_rr: 2-way grant with round-robin pointer and fixed-priority option.
- The top level holds the RAM mux and the response pipeline.

Test Plan:
- Solo write then read: M0 writes addr 0x00 = 0xAA0055BB, mask 1111; M0 reads 0x00 -> m0_rsp_valid pulses RAM_LAT cycles later with 0xAA0055BB; m1_rsp_valid stays 0.
- Byte mask: M1 writes 0x12 = 0xAA0055DD, then writes 0x00000033 mask 0001; M1 reads 0x12 -> 0xAA005533.
- Simultaneous requests, RR mode: both valid for 4 cycles -> grants M0, M1, M0, M1; RAM pins match each winner every cycle.
- Fixed mode: both valid continuously -> m1_req_ready stays 0 while M0 is valid; M1 is granted on the first cycle M0 drops valid.
- Interleaved reads: M0 reads 0x10 while M1 waits, then M1 reads 0x11 the next cycle (0x10 = 0x11111111, 0x11 = 0x22222222 preloaded) -> m0_rsp 0x11111111 then m1_rsp 0x22222222 on consecutive cycles, no cross-delivery.
- Reset mid-read: assert RST_N low the cycle after a read is accepted -> no rsp_valid, RAM pins idle during reset; after release the first tie is granted to M0.

Source files
------------

// File: rtl/dffram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dffram_arb_pkg
// Shared definitions for the two-master DFFRAM arbiter:
//   - default geometry (WORDS / WSIZE) and RAM read latency
//   - requester id type and the two id values
//   - arbitration mode encodings
//   - address-width helper used by the top and its interface
// ---------------------------------------------------------------------------
package dffram_arb_pkg;

    localparam int DEF_WORDS   = 128;
    localparam int DEF_WSIZE   = 4;
    localparam int DEF_RAM_LAT = 1;
    localparam int RAM_LAT_MAX = 3;

    typedef logic req_id_t;

    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // A one-word RAM still needs a one-bit address bus.
    function automatic int addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/dffram_arbiter_if.sv
// ---------------------------------------------------------------------------
// dffram_req_if
// One requester's view of the arbiter: a valid/ready request channel and an
// unstalled read-response channel.
//   req_valid  master->arb  request present
//   req_ready  arb->master  request accepted this cycle
//   req_we     master->arb  byte write mask, all zero = read
//   req_addr   master->arb  word address
//   req_wdata  master->arb  write data
//   rsp_valid  arb->master  one-cycle read data strobe
//   rsp_rdata  arb->master  read data, holds between strobes
// ---------------------------------------------------------------------------
interface dffram_req_if #(
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int WSIZE = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WSIZE-1:0] req_we;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/dffram_arbiter_arb2.sv
// ---------------------------------------------------------------------------
// arb2_rr
// Two-way combinational grant with a registered "last winner" pointer.
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   req_i      request vector, bit 0 = M0, bit 1 = M1
//   gnt_o      one-hot grant vector (or zero)
//   gnt_id_o   id of the granted requester (valid when gnt_vld_o)
//   gnt_vld_o  some requester is granted this cycle
// MODE = ARB_RR    : a tie goes to the requester that did not win last.
// MODE = ARB_FIXED : a tie always goes to M0.
// ---------------------------------------------------------------------------
module arb2_rr
    import dffram_arb_pkg::*;
#(
    parameter arb_mode_e MODE = ARB_RR
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output req_id_t    gnt_id_o,
    output logic       gnt_vld_o
);

    req_id_t last_q;
    req_id_t last_d;

    always_comb begin
        gnt_id_o  = REQ_M0;
        gnt_vld_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_id_o  = REQ_M0;
                gnt_vld_o = 1'b1;
            end
            2'b10: begin
                gnt_id_o  = REQ_M1;
                gnt_vld_o = 1'b1;
            end
            2'b11: begin
                gnt_vld_o = 1'b1;
                if (MODE == ARB_FIXED) begin
                    gnt_id_o = REQ_M0;
                end else begin
                    gnt_id_o = req_id_t'(~last_q);
                end
            end
            default: begin
                gnt_id_o  = REQ_M0;
                gnt_vld_o = 1'b0;
            end
        endcase
    end

    always_comb begin
        gnt_o = 2'b00;
        if (gnt_vld_o) begin
            gnt_o = (gnt_id_o == REQ_M1) ? 2'b10 : 2'b01;
        end
    end

    // Ready equals grant and a grant only goes to a valid requester, so
    // every grant is an acceptance and the pointer can follow it directly.
    always_comb begin
        last_d = last_q;
        if (gnt_vld_o) begin
            last_d = gnt_id_o;
        end
    end

    // Resetting to M1 makes M0 the winner of the first tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= REQ_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dffram_arbiter.sv
// ---------------------------------------------------------------------------
// dffram_arbiter
// Shares one single-port byte-maskable DFFRAM macro between two masters.
// Owns every RAM control pin; steers read data back to whichever master
// issued the read.
//   CLK    clock shared with the RAM macro
//   RST_N  asynchronous active-low reset
//   m0/m1  requester channels (dffram_req_if.slave)
//   EN0    RAM enable
//   WE0    RAM byte write enables
//   A0     RAM word address
//   Di0    RAM write data
//   Do0    RAM read data, valid RAM_LAT cycles after the sampling edge
// ---------------------------------------------------------------------------
module dffram_arbiter
    import dffram_arb_pkg::*;
#(
    parameter int WORDS    = DEF_WORDS,
    parameter int WSIZE    = DEF_WSIZE,
    parameter int RAM_LAT  = DEF_RAM_LAT,
    parameter int ARB_MODE = 0,
    localparam int AW      = addr_w(WORDS),
    localparam int DW      = 8 * WSIZE
) (
    input  logic             CLK,
    input  logic             RST_N,
    dffram_req_if.slave      m0,
    dffram_req_if.slave      m1,
    output logic             EN0,
    output logic [WSIZE-1:0] WE0,
    output logic [AW-1:0]    A0,
    output logic [DW-1:0]    Di0,
    input  logic [DW-1:0]    Do0
);

    localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic [1:0] req_vld;
    logic [1:0] gnt;
    req_id_t    gnt_id;
    logic       gnt_vld;
    logic       rd_issue;

    // Request valids are masked while reset is held so nothing is accepted
    // and the RAM pins stay idle even though the grant path is combinational.
    assign req_vld = {m1.req_valid, m0.req_valid} & {2{RST_N}};

    arb2_rr #(
        .MODE (MODE)
    ) u_arb (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .req_i     (req_vld),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    assign m0.req_ready = gnt[0];
    assign m1.req_ready = gnt[1];

    // -----------------------------------------------------------------------
    // RAM pin mux: driven straight from the granted request, zero when idle.
    // -----------------------------------------------------------------------
    always_comb begin
        EN0 = 1'b0;
        WE0 = '0;
        A0  = '0;
        Di0 = '0;
        if (gnt_vld) begin
            EN0 = 1'b1;
            if (gnt_id == REQ_M1) begin
                WE0 = m1.req_we;
                A0  = m1.req_addr;
                Di0 = m1.req_wdata;
            end else begin
                WE0 = m0.req_we;
                A0  = m0.req_addr;
                Di0 = m0.req_wdata;
            end
        end
    end

    assign rd_issue = EN0 && (WE0 == '0);

    // -----------------------------------------------------------------------
    // In-flight read tracking: a RAM_LAT-deep shift of (valid, owner id).
    // The tail lines up with the cycle in which Do0 carries that read's data.
    // -----------------------------------------------------------------------
    logic [RAM_LAT-1:0] pipe_vld_q;
    logic [RAM_LAT-1:0] pipe_vld_d;
    logic [RAM_LAT-1:0] pipe_id_q;
    logic [RAM_LAT-1:0] pipe_id_d;

    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_id_d     = pipe_id_q;
        pipe_vld_d[0] = rd_issue;
        pipe_id_d[0]  = gnt_id;
        for (int i = 1; i < RAM_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    // -----------------------------------------------------------------------
    // Response steering. Each master sees Do0 only during its own strobe and
    // otherwise keeps the last word it was handed.
    // -----------------------------------------------------------------------
    logic          rsp_vld;
    req_id_t       rsp_id;
    logic          rsp0;
    logic          rsp1;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata0_d;
    logic [DW-1:0] rdata1_q;
    logic [DW-1:0] rdata1_d;

    assign rsp_vld = pipe_vld_q[RAM_LAT-1];
    assign rsp_id  = pipe_id_q[RAM_LAT-1];
    assign rsp0    = rsp_vld && (rsp_id == REQ_M0);
    assign rsp1    = rsp_vld && (rsp_id == REQ_M1);

    assign rdata0_d = rsp0 ? Do0 : rdata0_q;
    assign rdata1_d = rsp1 ? Do0 : rdata1_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0.rsp_valid = rsp0;
    assign m1.rsp_valid = rsp1;
    assign m0.rsp_rdata = rdata0_d;
    assign m1.rsp_rdata = rdata1_d;

endmodule

// File: tb/tb_dffram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dffram_arbiter
// Two arbiters side by side (instance 0 round-robin, instance 1 fixed
// priority), each with its own behavioural RAM macro and its own pair of
// masters running the same request plan. A per-instance reference model
// predicts grants, RAM pins and read data from the arbitration rules; a
// separate monitor pops predicted responses and compares them.
// ---------------------------------------------------------------------------
module tb_dffram_arbiter;
    import dffram_arb_pkg::*;

    localparam int WORDS   = 128;
    localparam int WSIZE   = 4;
    localparam int RAM_LAT = 2;
    localparam int AW      = 7;
    localparam int DW      = 32;
    localparam int N_RAND  = 60;

    typedef struct {
        logic [WSIZE-1:0] we;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    wdata;
        int               gap;
    } item_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   plan_ready = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    item_t plan_m0[$];
    item_t plan_m1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic item_t mk(input logic [WSIZE-1:0] we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int gap);
        item_t it;
        it.we    = we;
        it.addr  = addr;
        it.wdata = wdata;
        it.gap   = gap;
        return it;
    endfunction

    function automatic item_t rnd_item();
        logic [WSIZE-1:0] we;
        logic [AW-1:0]    addr;
        we   = ($urandom_range(0, 1) == 0) ? '0 : WSIZE'($urandom_range(1, 15));
        addr = ($urandom_range(0, 9) == 0) ? AW'(WORDS - 1) : AW'($urandom_range(0, 23));
        return mk(we, addr, $urandom, $urandom_range(0, 3));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam arb_mode_e MODE = (g == 1) ? ARB_FIXED : ARB_RR;

        dffram_req_if #(.AW(AW), .DW(DW), .WSIZE(WSIZE)) mif [2] ();

        logic             en0;
        logic [WSIZE-1:0] we0;
        logic [AW-1:0]    a0;
        logic [DW-1:0]    di0;
        logic [DW-1:0]    do0;

        dffram_arbiter #(
            .WORDS    (WORDS),
            .WSIZE    (WSIZE),
            .RAM_LAT  (RAM_LAT),
            .ARB_MODE (g)
        ) u_dut (
            .CLK   (clk),
            .RST_N (rst_n),
            .m0    (mif[0]),
            .m1    (mif[1]),
            .EN0   (en0),
            .WE0   (we0),
            .A0    (a0),
            .Di0   (di0),
            .Do0   (do0)
        );

        // Behavioural RAM macro: samples at CLK, data RAM_LAT edges later.
        logic [DW-1:0] mem [WORDS];
        logic [DW-1:0] rd_pipe [RAM_LAT];
        bit            ram_init = 1'b0;

        always @(posedge clk) begin
            if (!ram_init) begin
                for (int i = 0; i < WORDS; i++) mem[i] <= '0;
                ram_init <= 1'b1;
            end else if (en0) begin
                for (int b = 0; b < WSIZE; b++)
                    if (we0[b]) mem[a0][8*b +: 8] <= di0[8*b +: 8];
            end
            rd_pipe[0] <= en0 ? mem[a0] : 32'hDEAD_BEEF;
            for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign do0 = rd_pipe[RAM_LAT-1];

        // Masters: hold each request until accepted, then optional idle gap.
        for (genvar m = 0; m < 2; m++) begin : g_m
            bit drv_done = 1'b0;
            initial begin : drv
                item_t it;
                bit    acc;
                int    n;
                mif[m].req_valid = 1'b0;
                mif[m].req_we    = '0;
                mif[m].req_addr  = '0;
                mif[m].req_wdata = '0;
                wait (plan_ready);
                @(posedge clk); #1;
                n = (m == 0) ? plan_m0.size() : plan_m1.size();
                for (int k = 0; k < n; k++) begin
                    if (m == 0) it = plan_m0[k];
                    else        it = plan_m1[k];
                    repeat (it.gap) begin @(posedge clk); #1; end
                    mif[m].req_valid = 1'b1;
                    mif[m].req_we    = it.we;
                    mif[m].req_addr  = it.addr;
                    mif[m].req_wdata = it.wdata;
                    acc = 1'b0;
                    while (!acc) begin
                        @(negedge clk);
                        acc = mif[m].req_ready;
                        @(posedge clk); #1;
                    end
                    mif[m].req_valid = 1'b0;
                end
                drv_done = 1'b1;
            end
        end

        // Reference model: grant rule, RAM pins, shadow memory.
        exp_t          exp_q[$];
        logic [DW-1:0] ref_mem [WORDS];
        bit            ref_init = 1'b0;
        int            last_gnt = 1;
        bit            rd_acc   = 1'b0;

        always @(negedge clk) begin : model
            int               w;
            logic [WSIZE-1:0] ew;
            logic [AW-1:0]    ea;
            logic [DW-1:0]    ed;
            logic [1:0]       rdy_exp;
            exp_t             e;
            if (!ref_init) begin
                for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
                ref_init = 1'b1;
            end
            rd_acc = 1'b0;
            if (!rst_n) begin
                last_gnt = 1;
                chk($sformatf("i%0d/rst_ready", g),
                    64'({mif[1].req_ready, mif[0].req_ready}), 64'd0);
                chk($sformatf("i%0d/rst_pins", g), 64'({en0, we0, a0, di0}), 64'd0);
            end else begin
                if (mif[0].req_valid && mif[1].req_valid)
                    w = (MODE == ARB_FIXED) ? 0 : 1 - last_gnt;
                else if (mif[0].req_valid) w = 0;
                else if (mif[1].req_valid) w = 1;
                else                       w = -1;
                rdy_exp = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
                chk($sformatf("i%0d/ready", g),
                    64'({mif[1].req_ready, mif[0].req_ready}), 64'(rdy_exp));
                ew = '0; ea = '0; ed = '0;
                if (w == 0) begin
                    ew = mif[0].req_we; ea = mif[0].req_addr; ed = mif[0].req_wdata;
                end else if (w == 1) begin
                    ew = mif[1].req_we; ea = mif[1].req_addr; ed = mif[1].req_wdata;
                end
                chk($sformatf("i%0d/ram_pins", g), 64'({en0, we0, a0, di0}),
                    64'({(w >= 0), ew, ea, ed}));
                if (w >= 0) begin
                    last_gnt = w;
                    if (ew == '0) begin
                        e.id   = w;
                        e.data = ref_mem[ea];
                        e.due  = cyc + RAM_LAT;
                        exp_q.push_back(e);
                        rd_acc = 1'b1;
                    end else begin
                        for (int b = 0; b < WSIZE; b++)
                            if (ew[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
                    end
                end
            end
        end

        // Monitor: pops the scoreboard whenever a response is due.
        logic [DW-1:0] last_rd0;
        logic [DW-1:0] last_rd1;
        bit   [1:0]    have_last = 2'b00;
        bit            q_empty   = 1'b1;

        always @(negedge clk) begin : monitor
            exp_t       e;
            int         owner;
            logic [1:0] rv;
            logic [1:0] rv_exp;
            rv = {mif[1].rsp_valid, mif[0].rsp_valid};
            if (!rst_n) begin
                chk($sformatf("i%0d/rst_rsp_valid", g), 64'(rv), 64'd0);
                exp_q.delete();
                have_last = 2'b00;
            end else begin
                owner  = -1;
                rv_exp = 2'b00;
                e.id = 0; e.data = '0; e.due = 0;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e      = exp_q.pop_front();
                    owner  = e.id;
                    rv_exp = (e.id == 1) ? 2'b10 : 2'b01;
                end
                chk($sformatf("i%0d/rsp_valid", g), 64'(rv), 64'(rv_exp));
                if (owner == 0) chk($sformatf("i%0d/m0_rdata", g), 64'(mif[0].rsp_rdata), 64'(e.data));
                if (owner == 1) chk($sformatf("i%0d/m1_rdata", g), 64'(mif[1].rsp_rdata), 64'(e.data));
                if (owner != 0 && have_last[0])
                    chk($sformatf("i%0d/m0_hold", g), 64'(mif[0].rsp_rdata), 64'(last_rd0));
                if (owner != 1 && have_last[1])
                    chk($sformatf("i%0d/m1_hold", g), 64'(mif[1].rsp_rdata), 64'(last_rd1));
                if (owner == 0) begin last_rd0 = e.data; have_last[0] = 1'b1; end
                if (owner == 1) begin last_rd1 = e.data; have_last[1] = 1'b1; end
            end
            q_empty = (exp_q.size() == 0);
        end
    end

    initial begin : main
        bit found;
        bit all_done;

        // Directed opening: solo write/read, byte mask, preload + interleaved reads.
        plan_m0.push_back(mk(4'hF, 7'h00, 32'hAA00_55BB, 0));
        plan_m0.push_back(mk(4'h0, 7'h00, 32'h0,         0));
        plan_m0.push_back(mk(4'hF, 7'h10, 32'h1111_1111, 0));
        plan_m0.push_back(mk(4'h0, 7'h10, 32'h0,         2));
        plan_m0.push_back(mk(4'h0, 7'h12, 32'h0,         0));
        plan_m0.push_back(mk(4'h0, 7'h11, 32'h0,         0));
        plan_m0.push_back(mk(4'h0, 7'h00, 32'h0,         0));
        plan_m1.push_back(mk(4'hF, 7'h12, 32'hAA00_55DD, 0));
        plan_m1.push_back(mk(4'h1, 7'h12, 32'h0000_0033, 0));
        plan_m1.push_back(mk(4'h0, 7'h12, 32'h0,         0));
        plan_m1.push_back(mk(4'hF, 7'h11, 32'h2222_2222, 0));
        plan_m1.push_back(mk(4'h0, 7'h11, 32'h0,         0));
        plan_m1.push_back(mk(4'h0, 7'h10, 32'h0,         0));
        for (int i = 0; i < N_RAND; i++) begin
            plan_m0.push_back(rnd_item());
            plan_m1.push_back(rnd_item());
        end
        plan_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset right after a read is accepted on the round-robin instance.
        repeat (30) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            if (g_inst[0].rd_acc) found = 1'b1;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        all_done = 1'b0;
        for (int i = 0; i < 6000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_inst[0].g_m[0].drv_done && g_inst[0].g_m[1].drv_done &&
                       g_inst[1].g_m[0].drv_done && g_inst[1].g_m[1].drv_done &&
                       g_inst[0].q_empty && g_inst[1].q_empty;
        end
        repeat (RAM_LAT + 3) @(posedge clk);
        n_checks++;
        if (!all_done || !found) begin
            n_errors++;
            $display("FAIL completion: all_done=%0d read_seen=%0d expected 1 and 1", all_done, found);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
